// File: rtl/run_checker.sv
// run_checker: pulses processor reset, waits for done with timeout,
// then reads result words and compares them against a loaded table.
module run_checker #(
    parameter int DW      = 8,
    parameter int AW      = 8,
    parameter int NCHK    = 2,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 4096,
    parameter int CW      = 16,
    localparam int IW     = (NCHK > 1) ? $clog2(NCHK) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            go,
    input  logic            exp_we,
    input  logic [IW-1:0]   exp_idx,
    input  logic [AW-1:0]   exp_addr,
    input  logic [DW-1:0]   exp_data,
    output logic            dut_reset,
    input  logic            dut_done,
    output logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy,
    output logic            finished,
    output logic            pass,
    output logic            fail,
    output logic            timed_out,
    output logic [NCHK-1:0] err_mask,
    output logic [CW-1:0]   cycles
);

    localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_RUN, S_RD, S_CMP, S_END
    } state_t;

    state_t          state;
    logic [RW-1:0]   rcnt;
    logic [IW-1:0]   ci;
    logic [IW-1:0]   cn;
    logic [NCHK-1:0] mask_nxt;
    logic            tbl_wr;

    logic [AW-1:0]   taddr [NCHK];
    logic [DW-1:0]   tdata [NCHK];

    assign cn     = ci + IW'(1);
    assign tbl_wr = exp_we && !busy
                    && ({1'b0, exp_idx} < (IW+1)'(NCHK));

    // Error mask as it will look after the current compare lands
    always_comb begin
        mask_nxt     = err_mask;
        mask_nxt[ci] = (mem_rdata != tdata[ci]);
    end

    // Expected table: loadable only while idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NCHK; k++) begin
                taddr[k] <= '0;
                tdata[k] <= '0;
            end
        end else if (tbl_wr) begin
            taddr[exp_idx] <= exp_addr;
            tdata[exp_idx] <= exp_data;
        end
    end

    // Run/check sequencer with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            rcnt      <= '0;
            ci        <= '0;
            dut_reset <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            finished  <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timed_out <= 1'b0;
            err_mask  <= '0;
            cycles    <= '0;
        end else begin
            finished <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        state     <= S_RST;
                        busy      <= 1'b1;
                        dut_reset <= 1'b1;
                        rcnt      <= '0;
                        ci        <= '0;
                        pass      <= 1'b0;
                        fail      <= 1'b0;
                        timed_out <= 1'b0;
                        err_mask  <= '0;
                        cycles    <= '0;
                    end
                end
                S_RST: begin
                    if (rcnt == RW'(RST_CYC - 1)) begin
                        dut_reset <= 1'b0;
                        state     <= S_RUN;
                    end else begin
                        rcnt <= rcnt + RW'(1);
                    end
                end
                S_RUN: begin
                    if (dut_done) begin
                        mem_addr <= taddr[ci];
                        state    <= S_RD;
                    end else begin
                        cycles <= cycles + CW'(1);
                        if (cycles == CW'(TIMEOUT - 1)) begin
                            timed_out <= 1'b1;
                            fail      <= 1'b1;
                            finished  <= 1'b1;
                            state     <= S_END;
                        end
                    end
                end
                S_RD: begin
                    state <= S_CMP;
                end
                S_CMP: begin
                    err_mask <= mask_nxt;
                    if (ci == IW'(NCHK - 1)) begin
                        pass     <= ~|mask_nxt;
                        fail     <= |mask_nxt;
                        finished <= 1'b1;
                        state    <= S_END;
                    end else begin
                        ci       <= cn;
                        mem_addr <= taddr[cn];
                        state    <= S_RD;
                    end
                end
                S_END: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_checker.sv
// tb_run_checker: scoreboard bench for run_checker with a processor
// model, a registered-read memory model and a reference result model.
module tb_run_checker;

    localparam int DW      = 8;
    localparam int AW      = 8;
    localparam int NCHK    = 2;
    localparam int RST_CYC = 2;
    localparam int TIMEOUT = 64;
    localparam int CW      = 16;
    localparam int IW      = 1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            go = 1'b0;
    logic            exp_we = 1'b0;
    logic [IW-1:0]   exp_idx = '0;
    logic [AW-1:0]   exp_addr = '0;
    logic [DW-1:0]   exp_data = '0;
    logic            dut_reset;
    logic            dut_done = 1'b0;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_rdata = '0;
    logic            busy;
    logic            finished;
    logic            pass;
    logic            fail;
    logic            timed_out;
    logic [NCHK-1:0] err_mask;
    logic [CW-1:0]   cycles;

    typedef struct {
        logic            p;
        logic            f;
        logic            to;
        logic [NCHK-1:0] m;
        int              cyc;
    } exp_t;

    exp_t          expq [$];
    logic [DW-1:0] mem [256];
    logic [AW-1:0] mt_addr [NCHK];
    logic [DW-1:0] mt_data [NCHK];
    int            dly = 1000000;
    int            kcnt = 0;
    int            hcnt = 0;
    int            n_chk = 0;
    int            n_pass = 0;

    run_checker #(
        .DW(DW), .AW(AW), .NCHK(NCHK), .RST_CYC(RST_CYC),
        .TIMEOUT(TIMEOUT), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .go(go),
        .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data),
        .dut_reset(dut_reset), .dut_done(dut_done),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .busy(busy), .finished(finished), .pass(pass),
        .fail(fail), .timed_out(timed_out),
        .err_mask(err_mask), .cycles(cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, want);
    endtask

    // Processor: done rises after dly low cycles out of reset
    always @(negedge clk) begin
        if (dly < 0) begin
            dut_done = 1'b1;
        end else if (dut_reset) begin
            kcnt = 0;
            dut_done = 1'b0;
        end else begin
            kcnt++;
            dut_done = (kcnt > dly);
        end
    end

    // Data memory with one-cycle read latency
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    // Monitor: scoreboard pop on finished, reset-pulse width
    always @(negedge clk) begin
        if (!reset) begin
            hcnt = 0;
        end else begin
            if (dut_reset) begin
                hcnt++;
            end else if (hcnt != 0) begin
                chk("dut_reset_width", hcnt, RST_CYC);
                hcnt = 0;
            end
            if (finished) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    $display("FAIL finished: got unexpected pulse, want none");
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("pass", pass, e.p);
                    chk("fail", fail, e.f);
                    chk("timed_out", timed_out, e.to);
                    chk("err_mask", err_mask, e.m);
                    chk("cycles", cycles, e.cyc);
                    chk("busy_in_end", busy, 1);
                end
            end
        end
    end

    function automatic exp_t model(input int d);
        exp_t e;
        e.to = (d >= TIMEOUT);
        e.m = '0;
        if (e.to) begin
            e.cyc = TIMEOUT;
        end else begin
            e.cyc = (d < 0) ? 0 : d;
            for (int i = 0; i < NCHK; i++)
                e.m[i] = (mem[mt_addr[i]] != mt_data[i]);
        end
        e.p = !e.to && (e.m == '0);
        e.f = !e.p;
        return e;
    endfunction

    task automatic tbl_write(input int idx, input int a, input int dt);
        @(negedge clk);
        exp_we = 1'b1;
        exp_idx = IW'(idx);
        exp_addr = AW'(a);
        exp_data = DW'(dt);
        @(posedge clk);
        #1 exp_we = 1'b0;
        mt_addr[idx] = AW'(a);
        mt_data[idx] = DW'(dt);
    endtask

    task automatic start_run(input int d, input bit push,
                             input bit wr, input int widx,
                             input int wa, input int wd);
        if (wr) begin
            mt_addr[widx] = AW'(wa);
            mt_data[widx] = DW'(wd);
        end
        if (push) expq.push_back(model(d));
        dly = d;
        @(negedge clk);
        go = 1'b1;
        exp_we = wr;
        exp_idx = IW'(widx);
        exp_addr = AW'(wa);
        exp_data = DW'(wd);
        @(posedge clk);
        #1 go = 1'b0;
        exp_we = 1'b0;
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (busy && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk("run_completes", busy, 0);
        @(negedge clk);
        chk("scoreboard_drained", expq.size(), 0);
    endtask

    task automatic load_basic();
        tbl_write(0, 2, 'hBC);
        tbl_write(1, 5, 'h41);
        mem[2] = 8'hBC;
        mem[5] = 8'h41;
    endtask

    initial begin
        logic [AW-1:0] a0;
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < NCHK; i++) begin
            mt_addr[i] = '0;
            mt_data[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_dut_reset", dut_reset, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_outputs", {finished, pass, fail, timed_out}, 0);
        chk("rst_err_mask", err_mask, 0);
        chk("rst_cycles", cycles, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Scenario 1: clean pass after 20 cycles
        load_basic();
        start_run(20, 1, 0, 0, 0, 0);
        wait_done();
        repeat (3) @(negedge clk);
        chk("pass_holds", pass, 1);
        chk("cycles_hold", cycles, 20);

        // Scenario 2: second word mismatches
        mem[5] = 8'h40;
        start_run(20, 1, 0, 0, 0, 0);
        wait_done();
        mem[5] = 8'h41;

        // Scenario 3: done never rises
        a0 = mem_addr;
        start_run(1000000, 1, 0, 0, 0, 0);
        wait_done();
        chk("timeout_no_reads", mem_addr, a0);

        // Timeout boundary: done on last allowed cycle vs one later
        start_run(TIMEOUT - 1, 1, 0, 0, 0, 0);
        wait_done();
        start_run(TIMEOUT, 1, 0, 0, 0, 0);
        wait_done();

        // Scenario 4: go during RUN, table write during CMP
        start_run(20, 1, 0, 0, 0, 0);
        repeat (5) @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        repeat (18) @(posedge clk);
        #1 exp_we = 1'b1;
        exp_idx = 1'b1;
        exp_addr = 8'h09;
        exp_data = 8'h00;
        @(posedge clk);
        #1 exp_we = 1'b0;
        wait_done();
        repeat (4) @(negedge clk);
        chk("go_not_queued", busy, 0);
        start_run(20, 1, 0, 0, 0, 0);
        wait_done();

        // Table write accepted together with go
        mem[7] = 8'h3C;
        start_run(6, 1, 1, 0, 7, 'h3C);
        wait_done();

        // Scenario 5: reset in CMP of check 0
        load_basic();
        start_run(10, 0, 0, 0, 0, 0);
        repeat (14) @(posedge clk);
        #1 chk("abort_in_check0", mem_addr, 2);
        #1 reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_dut_reset", dut_reset, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_flags", {finished, pass, fail, timed_out}, 0);
        chk("abort_err_mask", err_mask, 0);
        chk("abort_cycles", cycles, 0);
        for (int i = 0; i < NCHK; i++) begin
            mt_addr[i] = '0;
            mt_data[i] = '0;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        mem[0] = 8'h00;
        start_run(3, 1, 0, 0, 0, 0);
        wait_done();
        load_basic();
        start_run(20, 1, 0, 0, 0, 0);
        wait_done();

        // Scenario 6: done high from the start
        start_run(-1, 1, 0, 0, 0, 0);
        wait_done();

        // Randomized runs
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < NCHK; i++) begin
                int a;
                int dt;
                a = $urandom_range(0, 255);
                dt = $urandom_range(0, 255);
                tbl_write(i, a, dt);
                mem[a] = ($urandom_range(0, 1) == 1)
                         ? DW'(dt) : DW'(dt ^ (1 << $urandom_range(0, 7)));
            end
            start_run($urandom_range(0, TIMEOUT + 6), 1, 0, 0, 0, 0);
            wait_done();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
